pc_fetch16: RTL and testbench



---
 rtl/pc_fetch16.sv | 120 ++++++++++++
 tb/tb_pc_fetch16.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch16.sv
// Purpose: 16-bit program counter that issues fetch addresses to instruction memory; advance, redirect and park.
// Latency: all outputs registered; a redirect (load/clr) or an accepted advance shows on out one cycle later.
// Backpressure: out holds while addr_valid=1 and addr_ready=0; inc without accept is dropped, not queued.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in[15:0], load        jump target and redirect strobe
//   inc                   request sequential advance (only honoured on accept)
//   clr                   soft clear to RESET_ADDR, also clears wrap
//   halt                  park the fetch stream (addr_valid drops next cycle)
//   addr_ready            instruction memory accepts out this cycle
//   out[15:0], addr_valid fetch request
//   wrap                  sticky: a sequential advance went FFFF -> 0000
//   fetch_cnt[31:0]       accepted-fetch counter, present only with PC_FETCH_COUNT_EN defined

module inc16 (
    input  logic [15:0] in,
    output logic [15:0] out
);
    assign out = in + 16'd1;
endmodule

module pc_fetch16 #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        inc,
    input  logic        clr,
    input  logic        halt,
    input  logic        addr_ready,
    output logic [15:0] out,
    output logic        addr_valid,
    output logic        wrap
`ifdef PC_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RST     = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_seq;
    logic [15:0] pc_nxt;
    logic        wrap_nxt;
    logic        acc;

    inc16 u_inc16 (
        .in  (out),
        .out (pc_seq)
    );

    assign acc = addr_valid & addr_ready;

    // Next state: halt parks from any live state; releasing halt resumes fetching.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:    state_nxt = halt ? ST_HALTED : ST_FETCH;
            ST_FETCH:  state_nxt = halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_nxt = halt ? ST_HALTED : ST_FETCH;
            default:   state_nxt = ST_RST;
        endcase
    end

    // PC update, priority clr > load > accepted inc. load/clr act in every state
    // so a redirect while halted is the first address presented on resume.
    always_comb begin
        pc_nxt   = out;
        wrap_nxt = wrap;
        if (clr) begin
            pc_nxt   = RESET_ADDR;
            wrap_nxt = 1'b0;
        end else if (load) begin
            pc_nxt = in;
        end else if (inc && acc) begin
            pc_nxt = pc_seq;
            if (out == 16'hFFFF) begin
                wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RST;
            out        <= RESET_ADDR;
            addr_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_nxt;
            out        <= pc_nxt;
            // Registered copy of the FETCH decode so addr_valid comes straight from a flop.
            addr_valid <= (state_nxt == ST_FETCH);
            wrap       <= wrap_nxt;
        end
    end

`ifdef PC_FETCH_COUNT_EN
    // clr takes precedence over a simultaneous accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
        end else if (clr) begin
            fetch_cnt <= 32'd0;
        end else if (acc) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch16.sv
module tb_pc_fetch16;

    localparam logic [15:0] RST_ADDR = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic        load, inc, clr, halt, addr_ready;
    logic [15:0] out;
    logic        addr_valid;
    logic        wrap;
`ifdef PC_FETCH_COUNT_EN
    logic [31:0] fetch_cnt;
`endif

    always #5 clk = ~clk;

    pc_fetch16 #(.RESET_ADDR(RST_ADDR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .load       (load),
        .inc        (inc),
        .clr        (clr),
        .halt       (halt),
        .addr_ready (addr_ready),
        .out        (out),
        .addr_valid (addr_valid),
        .wrap       (wrap)
`ifdef PC_FETCH_COUNT_EN
        ,
        .fetch_cnt  (fetch_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the architectural view (current address, fetching or not,
    // sticky wrap, accepted-fetch count) advanced one clock at a time.
    logic [15:0] m_pc   = RST_ADDR;
    bit          m_vld  = 1'b0;
    bit          m_wrap = 1'b0;
    logic [31:0] m_cnt  = 32'd0;

    // Addresses the DUT actually handed to memory (out sampled on each accept).
    logic [15:0] acc_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit c, input bit l, input bit i,
                        input bit h, input bit rdy, input logic [15:0] d);
        bit acc;
        rst_n      = r;
        clr        = c;
        load       = l;
        inc        = i;
        halt       = h;
        addr_ready = rdy;
        in         = d;
        if (r && addr_valid && rdy) acc_log.push_back(out);
        if (!r) begin
            m_pc   = RST_ADDR;
            m_vld  = 1'b0;
            m_wrap = 1'b0;
            m_cnt  = 32'd0;
        end else begin
            acc = m_vld && rdy;
            if (acc) m_cnt = m_cnt + 32'd1;
            if (c) begin
                m_pc   = RST_ADDR;
                m_wrap = 1'b0;
                m_cnt  = 32'd0;
            end else if (l) begin
                m_pc = d;
            end else if (i && acc) begin
                if (m_pc == 16'hFFFF) m_wrap = 1'b1;
                m_pc = 16'((32'(m_pc) + 32'd1) % 32'd65536);
            end
            m_vld = !h;
        end
        @(posedge clk);
        #1;
        chk("out", 32'(out), 32'(m_pc));
        chk("addr_valid", 32'(addr_valid), 32'(m_vld));
        chk("wrap", 32'(wrap), 32'(m_wrap));
`ifdef PC_FETCH_COUNT_EN
        chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; inc = 1'b0;
        halt = 1'b0; addr_ready = 1'b0; in = 16'h0000;

        // Reset two cycles, then sequential run
        step(0, 0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 0, 0, 16'h0);
        chk("rst_out", 32'(out), 32'h0000);
        chk("rst_valid", 32'(addr_valid), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        acc_log.delete();
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 0, 1, 16'h0);
        chk("seq_count", 32'(acc_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < acc_log.size()) chk("seq_addr", 32'(acc_log[k]), 32'(k));
        chk("seq_out", 32'(out), 32'h0004);

        // Backpressure at 0005
        step(1, 0, 0, 1, 0, 1, 16'h0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 1, 0, 0, 16'h0);
            chk("bp_hold", 32'(out), 32'h0005);
            chk("bp_valid", 32'(addr_valid), 32'h1);
        end
        step(1, 0, 0, 1, 0, 1, 16'h0);
        chk("bp_release", 32'(out), 32'h0006);

        // Priority: load beats inc, clr beats load
        step(1, 0, 1, 0, 0, 0, 16'h0010);
        step(1, 0, 1, 1, 0, 1, 16'h1234);
        chk("prio_load", 32'(out), 32'h1234);
        step(1, 0, 1, 0, 0, 0, 16'h0010);
        step(1, 1, 1, 1, 0, 1, 16'h1234);
        chk("prio_clr", 32'(out), 32'h0000);
        chk("prio_clr_wrap", 32'(wrap), 32'h0);
        chk("prio_acc_old", 32'(acc_log[$]), 32'h0010);

        // Wrap-around
        step(1, 0, 1, 0, 0, 0, 16'hFFFF);
        step(1, 0, 0, 1, 0, 1, 16'h0);
        chk("wrap_out", 32'(out), 32'h0000);
        chk("wrap_set", 32'(wrap), 32'h1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 1, 16'h0);
        chk("wrap_sticky", 32'(wrap), 32'h1);
        step(1, 1, 0, 0, 0, 0, 16'h0);
        chk("wrap_clr", 32'(wrap), 32'h0);

        // Halt
        step(1, 0, 1, 0, 0, 0, 16'h0020);
        step(1, 0, 0, 1, 1, 1, 16'h0);
        chk("halt_out", 32'(out), 32'h0021);
        chk("halt_valid", 32'(addr_valid), 32'h0);
        step(1, 0, 0, 1, 1, 1, 16'h0);
        chk("halt_noinc", 32'(out), 32'h0021);
        step(1, 0, 1, 0, 1, 1, 16'h0100);
        chk("halt_load", 32'(out), 32'h0100);
        step(1, 0, 0, 0, 0, 1, 16'h0);
        chk("resume_valid", 32'(addr_valid), 32'h1);
        chk("resume_out", 32'(out), 32'h0100);

        // Counter and reset mid-handshake
        step(1, 1, 0, 0, 0, 0, 16'h0);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 0, 1, 16'h0);
`ifdef PC_FETCH_COUNT_EN
        chk("cnt_five", fetch_cnt, 32'd5);
`endif
        step(1, 0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 1, 0, 0, 16'h0);
        chk("midrst_out", 32'(out), 32'(RST_ADDR));
        chk("midrst_valid", 32'(addr_valid), 32'h0);
`ifdef PC_FETCH_COUNT_EN
        chk("midrst_cnt", fetch_cnt, 32'd0);
`endif

        // Randomised phase against the model
        for (int k = 0; k < 400; k++) begin
            logic [15:0] d;
            if ($urandom_range(0, 3) == 0) d = 16'hFFFD + 16'($urandom_range(0, 2));
            else d = 16'($urandom);
            step($urandom_range(0, 31) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1,
                 d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
